// File: rtl/xdbladd_engine_if.sv
// Handshake bundle between the xDBLADD step engine and the shared modular
// arithmetic unit. The engine drives operands, opcode and rst_mul. The unit
// returns mul and done_mul.
interface xdbladd_engine_if #(
    parameter int N = 512
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic         rst_mul;
    logic [N-1:0] mul;
    logic         done_mul;

    // Engine side: issues operations and consumes results.
    modport master (
        output a,
        output b,
        output op,
        output rst_mul,
        input  mul,
        input  done_mul
    );

    // Arithmetic-unit side.
    modport slave (
        input  a,
        input  b,
        input  op,
        input  rst_mul,
        output mul,
        output done_mul
    );
endinterface

// File: rtl/xdbladd_engine.sv
// xDBLADD ladder-step engine for x-only Montgomery curves (A:C).
// It computes R = 2P and S = P + Q, with PQ = P - Q, as a fixed 23-step
// schedule on one shared modular arithmetic unit. rst doubles as start.
// The operand snapshot is taken while rst is high.
module xdbladd_engine #(
    parameter int N = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] px_i,
    input  logic [N-1:0] pz_i,
    input  logic [N-1:0] qx_i,
    input  logic [N-1:0] qz_i,
    input  logic [N-1:0] pqx_i,
    input  logic [N-1:0] pqz_i,
    input  logic [N-1:0] ax_i,
    input  logic [N-1:0] az_i,
    output logic [N-1:0] rx_o,
    output logic [N-1:0] rz_o,
    output logic [N-1:0] sx_o,
    output logic [N-1:0] sz_o,
    output logic         done_o,
    xdbladd_engine_if.master mau
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10
    } op_e;

    localparam logic [4:0] LAST_STEP = 5'd22;

    state_e       state_q, state_d;
    logic [4:0]   step_q, step_d;
    logic         capture;

    // Input snapshot, refreshed every cycle rst is high.
    logic [N-1:0] px_q, pz_q, qx_q, qz_q, pqx_q, pqz_q, ax_q, az_q;

    // Schedule temporaries.
    logic [N-1:0] t_q, a24_q, c24_q;
    logic [N-1:0] a_q, b_q, c_q, d_q;
    logic [N-1:0] aa_q, bb_q, e_q, f_q, g_q, h_q;
    logic [N-1:0] da_q, cb_q, sp_q, sm_q, sp2_q, sm2_q;

    // Results.
    logic [N-1:0] rx_q, rz_q, sx_q, sz_q;

    // Operand selection for the current step.
    op_e          op_sel;
    logic [N-1:0] opa, opb;
    logic         active;

    // Control state register. rst forces IDLE and rewinds the schedule.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next-state logic. done_mul counts only in WAIT, so a stale result is never taken.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mau.done_mul && !rst) begin
                    capture = 1'b1;
                    step_d  = step_q + 5'd1;
                    state_d = (step_q == LAST_STEP) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // The fixed operation schedule. Step sets the opcode and the two operands.
    always_comb begin
        op_sel = OP_MUL;
        opa    = '0;
        opb    = '0;
        case (step_q)
            5'd0:  begin op_sel = OP_ADD; opa = az_q;  opb = az_q;  end
            5'd1:  begin op_sel = OP_ADD; opa = ax_q;  opb = t_q;   end
            5'd2:  begin op_sel = OP_ADD; opa = t_q;   opb = t_q;   end
            5'd3:  begin op_sel = OP_ADD; opa = px_q;  opb = pz_q;  end
            5'd4:  begin op_sel = OP_SUB; opa = px_q;  opb = pz_q;  end
            5'd5:  begin op_sel = OP_ADD; opa = qx_q;  opb = qz_q;  end
            5'd6:  begin op_sel = OP_SUB; opa = qx_q;  opb = qz_q;  end
            5'd7:  begin op_sel = OP_MUL; opa = a_q;   opb = a_q;   end
            5'd8:  begin op_sel = OP_MUL; opa = b_q;   opb = b_q;   end
            5'd9:  begin op_sel = OP_SUB; opa = aa_q;  opb = bb_q;  end
            5'd10: begin op_sel = OP_MUL; opa = c24_q; opb = bb_q;  end
            5'd11: begin op_sel = OP_MUL; opa = f_q;   opb = aa_q;  end
            5'd12: begin op_sel = OP_MUL; opa = a24_q; opb = e_q;   end
            5'd13: begin op_sel = OP_ADD; opa = f_q;   opb = g_q;   end
            5'd14: begin op_sel = OP_MUL; opa = h_q;   opb = e_q;   end
            5'd15: begin op_sel = OP_MUL; opa = d_q;   opb = a_q;   end
            5'd16: begin op_sel = OP_MUL; opa = c_q;   opb = b_q;   end
            5'd17: begin op_sel = OP_ADD; opa = da_q;  opb = cb_q;  end
            5'd18: begin op_sel = OP_SUB; opa = da_q;  opb = cb_q;  end
            5'd19: begin op_sel = OP_MUL; opa = sp_q;  opb = sp_q;  end
            5'd20: begin op_sel = OP_MUL; opa = sm_q;  opb = sm_q;  end
            5'd21: begin op_sel = OP_MUL; opa = pqz_q; opb = sp2_q; end
            5'd22: begin op_sel = OP_MUL; opa = pqx_q; opb = sm2_q; end
            default: begin op_sel = OP_MUL; opa = '0; opb = '0; end
        endcase
    end

    // Unit-facing outputs. Operands are driven only during ISSUE and WAIT.
    // rst gates everything at once, so an abort takes effect in the same cycle.
    always_comb begin
        active      = !rst && (state_q == S_ISSUE || state_q == S_WAIT);
        mau.a       = active ? opa : '0;
        mau.b       = active ? opb : '0;
        mau.op      = active ? op_sel : OP_MUL;
        mau.rst_mul = !(!rst && state_q == S_WAIT);
        done_o      = !rst && (state_q == S_DONE);
    end

    // Input snapshot and temporary capture. Each run writes a temporary before reading it.
    // NOTE: datapath registers carry no reset; only control and visible results need a known value.
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q  <= px_i;
            pz_q  <= pz_i;
            qx_q  <= qx_i;
            qz_q  <= qz_i;
            pqx_q <= pqx_i;
            pqz_q <= pqz_i;
            ax_q  <= ax_i;
            az_q  <= az_i;
        end
        if (capture) begin
            case (step_q)
                5'd0:  t_q   <= mau.mul;
                5'd1:  a24_q <= mau.mul;
                5'd2:  c24_q <= mau.mul;
                5'd3:  a_q   <= mau.mul;
                5'd4:  b_q   <= mau.mul;
                5'd5:  c_q   <= mau.mul;
                5'd6:  d_q   <= mau.mul;
                5'd7:  aa_q  <= mau.mul;
                5'd8:  bb_q  <= mau.mul;
                5'd9:  e_q   <= mau.mul;
                5'd10: f_q   <= mau.mul;
                5'd12: g_q   <= mau.mul;
                5'd13: h_q   <= mau.mul;
                5'd15: da_q  <= mau.mul;
                5'd16: cb_q  <= mau.mul;
                5'd17: sp_q  <= mau.mul;
                5'd18: sm_q  <= mau.mul;
                5'd19: sp2_q <= mau.mul;
                5'd20: sm2_q <= mau.mul;
                default: ;
            endcase
        end
    end

    // Result registers. Cleared on rst, so no partial result survives an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= '0;
            rz_q <= '0;
            sx_q <= '0;
            sz_q <= '0;
        end else if (capture) begin
            case (step_q)
                5'd11: rx_q <= mau.mul;
                5'd14: rz_q <= mau.mul;
                5'd21: sx_q <= mau.mul;
                5'd22: sz_q <= mau.mul;
                default: ;
            endcase
        end
    end

    assign rx_o = rx_q;
    assign rz_o = rz_q;
    assign sx_o = sx_q;
    assign sz_o = sz_q;

endmodule

// File: tb/tb_xdbladd_engine.sv
// Self-checking bench for xdbladd_engine. An exact Montgomery arithmetic unit
// model over the CSIDH-512 prime sits on the interface. All points use small
// integers in Montgomery form, so each expected result is a hand-computed
// integer mapped into Montgomery form.
module tb_xdbladd_engine;

    localparam int N = 512;
    localparam logic [N-1:0] P =
        512'h65b48e8f740f89bffc8ab0d15e3e4c4ab42d083aedc88c425afbfcc69322c9cda7aac6c567f35507516730cc1f0b4f25c2721bf457aca8351b81b90533c6c87b;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] px, pz, qx, qz, pqx, pqz, ax, az;
    logic [N-1:0] rx, rz, sx, sz;
    logic         done;

    always #5 clk = ~clk;

    xdbladd_engine_if #(.N(N)) mau_if ();

    xdbladd_engine #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .px_i   (px),
        .pz_i   (pz),
        .qx_i   (qx),
        .qz_i   (qz),
        .pqx_i  (pqx),
        .pqz_i  (pqz),
        .ax_i   (ax),
        .az_i   (az),
        .rx_o   (rx),
        .rz_o   (rz),
        .sx_o   (sx),
        .sz_o   (sz),
        .done_o (done),
        .mau    (mau_if)
    );

    // ---------------- field arithmetic reference ----------------
    function automatic logic [N-1:0] mont_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N+1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) t = t + {2'b00, y};
            if (t[0]) t = t + {2'b00, P};
            t = t >> 1;
        end
        if (t >= {2'b00, P}) t = t - {2'b00, P};
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + {1'b0, P} - {1'b0, y};
        return s[N-1:0];
    endfunction

    // k * R mod p, with R = 2^N.
    function automatic logic [N-1:0] to_mont(input int k);
        logic [2*N-1:0] w, pw, kw;
        pw = {{N{1'b0}}, P};
        w  = '0;
        w[N] = 1'b1;
        w  = w % pw;
        kw = '0;
        kw[31:0] = k;
        w  = (w * kw) % pw;
        return w[N-1:0];
    endfunction

    // ---------------- arithmetic unit model ----------------
    int           k_wait   = 1;
    bit           stale    = 1'b0;
    int           wait_cnt = 0;
    logic [N-1:0] mul_r    = '0;

    always @(posedge clk) begin
        if (mau_if.rst_mul) begin
            wait_cnt <= 1;
            case (mau_if.op)
                2'b00:   mul_r <= mont_mul(mau_if.a, mau_if.b);
                2'b01:   mul_r <= mod_add(mau_if.a, mau_if.b);
                2'b10:   mul_r <= mod_sub(mau_if.a, mau_if.b);
                default: mul_r <= '0;
            endcase
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    assign mau_if.mul      = mul_r;
    assign mau_if.done_mul = stale ? (mau_if.rst_mul || wait_cnt == k_wait)
                                   : (!mau_if.rst_mul && wait_cnt == k_wait);

    // rst_mul falling-edge monitor: counts starts and logs the opcode of each.
    int         pulses  = 0;
    logic       last_rm = 1'b1;
    logic [1:0] op_log [0:511];

    always @(posedge clk) begin
        if (last_rm && !mau_if.rst_mul) begin
            if (pulses < 512) op_log[pulses] <= mau_if.op;
            pulses <= pulses + 1;
        end
        last_rm <= mau_if.rst_mul;
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int px, pz, qx, qz, pqx, pqz, ax, az;
        int k;
        bit stl;
        int rx, rz, sx, sz;
        int lat;
    } vec_t;

    vec_t vecs [4];

    logic [1:0] exp_ops [0:22] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0,
                                   2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0,
                                   2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};

    // Load vector idx, hold rst for two cycles, check reset state, then release.
    task automatic start_vec(input int idx, output int base);
        vec_t v;
        v      = vecs[idx];
        k_wait = v.k;
        stale  = v.stl;
        px  = to_mont(v.px);  pz  = to_mont(v.pz);
        qx  = to_mont(v.qx);  qz  = to_mont(v.qz);
        pqx = to_mont(v.pqx); pqz = to_mont(v.pqz);
        ax  = to_mont(v.ax);  az  = to_mont(v.az);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("v%0d rst done", idx),    N'(done), N'(0));
        check($sformatf("v%0d rst rst_mul", idx), N'(mau_if.rst_mul), N'(1));
        check($sformatf("v%0d rst op", idx),      N'(mau_if.op), N'(0));
        check($sformatf("v%0d rst A", idx),       mau_if.a, '0);
        check($sformatf("v%0d rst B", idx),       mau_if.b, '0);
        check($sformatf("v%0d rst Rx", idx),      rx, '0);
        check($sformatf("v%0d rst Sz", idx),      sz, '0);
        base = pulses;
        rst  = 1'b0;
        // Inputs changed after release must have no effect.
        px = ~px; pz = ~pz; qx = ~qx; qz = ~qz;
        pqx = ~pqx; pqz = ~pqz; ax = ~ax; az = ~az;
    endtask

    // Wait for done (bounded), then check latency, op sequence and results.
    task automatic finish_vec(input int idx, input int base);
        vec_t v;
        int   cnt;
        bit   seen;
        v    = vecs[idx];
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        check($sformatf("v%0d done latency", idx), N'(cnt - 1), N'(v.lat));
        check($sformatf("v%0d start count", idx), N'(pulses - base), N'(23));
        for (int i = 0; i < 23; i++)
            check($sformatf("v%0d op%0d", idx, i), N'(op_log[base + i]), N'(exp_ops[i]));
        check($sformatf("v%0d Rx", idx), rx, to_mont(v.rx));
        check($sformatf("v%0d Rz", idx), rz, to_mont(v.rz));
        check($sformatf("v%0d Sx", idx), sx, to_mont(v.sx));
        check($sformatf("v%0d Sz", idx), sz, to_mont(v.sz));
    endtask

    task automatic run_vec(input int idx);
        int base;
        start_vec(idx, base);
        finish_vec(idx, base);
    endtask

    initial begin
        int base;
        int lows;
        int p0;
        bit reached;

        rst = 1'b1;
        px = '0; pz = '0; qx = '0; qz = '0; pqx = '0; pqz = '0; ax = '0; az = '0;

        // px pz qx qz pqx pqz ax az | k stale | Rx Rz Sx Sz | latency
        vecs[0] = '{2, 1, 2, 1, 2, 1, 0, 1, 3, 1'b0,   36,   160,    36, 0,  92};
        vecs[1] = '{1, 0, 3, 1, 5, 2, 0, 1, 2, 1'b0,    4,     0,    72, 20, 69};
        vecs[2] = '{3, 1, 2, 1, 1, 1, 6, 1, 1, 1'b1,  256,  1344,   100, 4,  46};
        vecs[3] = '{5, 2, 7, 3, 2, 5, 3, 2, 4, 1'b0, 3528, 14080, 16820, 8, 115};

        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Done hold: results and done stay put, and no new start is issued.
        p0   = pulses;
        lows = 0;
        repeat (50) begin
            @(negedge clk);
            if (done !== 1'b1) lows++;
        end
        check("hold done low cycles", N'(lows), N'(0));
        check("hold starts", N'(pulses - p0), N'(0));
        check("hold Rx", rx, to_mont(vecs[3].rx));
        check("hold Rz", rz, to_mont(vecs[3].rz));
        check("hold Sx", sx, to_mont(vecs[3].sx));
        check("hold Sz", sz, to_mont(vecs[3].sz));
        rst = 1'b1;
        @(negedge clk);
        check("hold rst done", N'(done), N'(0));
        check("hold rst rst_mul", N'(mau_if.rst_mul), N'(1));

        // Mid-operation abort at step 12, then a rerun with new inputs.
        start_vec(0, base);
        reached = 1'b0;
        for (int c = 0; c < 2000 && !reached; c++) begin
            @(negedge clk);
            if (pulses - base >= 13) reached = 1'b1;
        end
        check("abort reached step12", N'(reached), N'(1));
        check("abort done before", N'(done), N'(0));
        run_vec(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
